// File: rtl/uart_pkg.sv
// UART shared definitions: default baud timing, counter width and receiver state encoding.
// Used by both the transmitter and the receiver so their bit timing always agrees.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 25000000;
  localparam int BAUDRATE_DEF = 921600;
  localparam int CNT_W        = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int calc_bit_clks(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

  // Mid-point of the start bit, measured from the cycle the low level is first seen.
  function automatic int calc_half_bit(input int bit_clks);
    return (bit_clks - 1) / 2;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle (high) level.
// Latency: 2 cycles. No backpressure: samples every cycle.
// Reset-to-1 keeps a reset release from looking like a start bit.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_module.sv
// UART receiver, 8N1 LSB-first (8E1 when UART_RX_PARITY_EN is defined), 1-cycle data_valid strobe.
// Latency: 3 + half_bit + 9*bit_clks cycles from the first synchronizer capture of the start bit (+bit_clks with parity).
// No backpressure: data_out is overwritten by each good frame; the consumer must take it on the strobe.
module rx_module
  import uart_pkg::*;
#(
  parameter int clk_freq = CLK_FREQ_DEF,
  parameter int baudrate = BAUDRATE_DEF,
  parameter int bit_clks = calc_bit_clks(clk_freq, baudrate),
  parameter int half_bit = calc_half_bit(bit_clks)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [CNT_W-1:0] bit_end  = CNT_W'(bit_clks - 1);
  localparam logic [CNT_W-1:0] half_end = CNT_W'(half_bit);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             rx_s;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == half_end) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              // Line went back high before mid-bit: treat as noise.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == bit_end) begin
            shift[idx] <= rx_s;
            cnt        <= '0;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == bit_end) begin
            par_bit <= rx_s;
            cnt     <= '0;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leaving at the stop-bit mid-point lets a back-to-back start bit be caught.
          if (cnt == bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_bit != ^shift) begin
                parity_err <= 1'b1;
              end else begin
                data_out   <= shift;
                data_valid <= 1'b1;
              end
`else
              data_out   <= shift;
              data_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
